// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum feature is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between a word source / memory and the loader.
// The checksum signal exists only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if #(
    parameter int ADDR_W = imem_pkg::DEFAULT_ADDR_W,
    parameter int CNT_W  = 7
);
    // Word handshake: a word transfers on a rising clk edge where in_valid and
    // in_ready are both 1; in_data is only looked at in that cycle, and the
    // source may raise or drop in_valid freely when no transfer happens.
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        checksum;

    modport master (
        output start, base_addr, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
    );
    modport slave (
        input  start, base_addr, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
    );
`else
    modport master (
        output start, base_addr, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
    modport slave (
        input  start, base_addr, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
`endif
endinterface

// File: rtl/imem_word_serializer.sv
// Holds one accepted 32-bit word and presents its bytes MSB-first,
// one byte per advance.
module imem_word_serializer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] word_in,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= word_in;
            idx_q  <= '0;
        end else if (advance) begin
            idx_q  <= idx_q + 2'd1;
        end
    end

    // Index 0 selects the most significant byte so memory ends up big-endian.
    always_comb begin
        byte_out = word_q[31:24];
        case (idx_q)
            2'd0: byte_out = word_q[31:24];
            2'd1: byte_out = word_q[23:16];
            2'd2: byte_out = word_q[15:8];
            2'd3: byte_out = word_q[7:0];
            default: byte_out = word_q[31:24];
        endcase
    end

    assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a run of 32-bit words into a byte-wide instruction memory, big-endian.
// Define IMEM_LOADER_CHECKSUM_EN to add a running byte checksum output.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus,
    output loader_state_t state_dbg
);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [CNT_W-1:0]  remaining;
    logic              in_ready_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              done_q;
    logic              handshake;
    logic [7:0]        byte_sel;
    logic              last_byte;

    assign handshake = (state == ACCEPT) && bus.in_valid && in_ready_q;

    imem_word_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (handshake),
        .advance   (state == WRITE),
        .word_in   (bus.in_data),
        .byte_out  (byte_sel),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            remaining  <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_cnt  <= bus.base_addr;
                        remaining <= bus.word_count;
                        busy_q    <= 1'b1;
                        if (bus.word_count != '0) begin
                            state      <= ACCEPT;
                            in_ready_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (handshake) begin
                        state      <= WRITE;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    // Address wraps naturally at 2^ADDR_W.
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    if (last_byte) begin
                        remaining <= remaining - CNT_W'(1);
                        mem_we_q  <= 1'b0;
                        if (remaining != CNT_W'(1)) begin
                            state      <= ACCEPT;
                            in_ready_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (state == IDLE && bus.start) begin
            checksum_q <= '0;
        end else if (mem_we_q) begin
            checksum_q <= checksum_q + byte_sel;
        end
    end

    assign bus.checksum = checksum_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_cnt;
    assign bus.mem_wdata = byte_sel;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign state_dbg     = state;

endmodule
